// File: rtl/bit_serial_add_sequencer_pkg.sv
// Shared definitions for the bit-serial add sequencer.
//   bsa_state_e : controller states (IDLE, ISSUE, WAIT, DONE)
//   bsa_idx_w   : width of the bit index for a given operand width
//   bsa_cnt_w   : width of the latency down-counter for a given adder latency
package bit_serial_add_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } bsa_state_e;

  localparam int BSA_MIN_W = 1;

  // Bit index must address bits 0..width-1.
  function automatic int bsa_idx_w(input int width);
    return (width > 1) ? $clog2(width) : BSA_MIN_W;
  endfunction

  // Counter holds values 0..fa_lat-1; sized for fa_lat+1 so fa_lat=1 still gets one bit.
  function automatic int bsa_cnt_w(input int fa_lat);
    return (fa_lat > 0) ? $clog2(fa_lat + 1) : BSA_MIN_W;
  endfunction

endpackage

// File: rtl/bsa_lat_timer.sv
// Loadable down-counter that marks when the adder result for the last issued
// bit triple is available.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : reload with FA_LAT-1 (asserted in the issue cycle)
//   en         : count down while waiting; holds at zero, never wraps
//   zero       : counter reads zero (FA_LAT cycles after the load cycle)
module bsa_lat_timer
  import bit_serial_add_sequencer_pkg::*;
#(
  parameter int FA_LAT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int CNT_W = bsa_cnt_w(FA_LAT);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(FA_LAT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/bit_serial_add_sequencer.sv
// Bit-serial WIDTH-bit adder controller driving an external fixed-latency
// full adder, LSB first, carry fed back from fa_cout.
//   in_valid/in_ready, in_a, in_b, in_cin : operand transaction
//   fa_a, fa_b, fa_c, fa_issue            : bit triple to the adder (zero unless issuing)
//   fa_s, fa_cout                         : adder results, FA_LAT cycles after issue
//   out_valid/out_ready, out_sum,
//   out_cout, out_ovf                     : result transaction, held under backpressure
module bit_serial_add_sequencer
  import bit_serial_add_sequencer_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int FA_LAT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  output logic             fa_issue,
  input  logic             fa_s,
  input  logic             fa_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int IDX_W = bsa_idx_w(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  bsa_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [IDX_W-1:0] bit_idx_q;
  logic             carry_q;
  logic             msb_cin_q;
  logic             accept;
  logic             sample;
  logic             last_bit;
  logic             lat_zero;

  // Signed overflow: carry into the MSB differs from carry out of it.
  function automatic logic ovf_of(input logic c_into_msb, input logic c_out_msb);
    return c_into_msb ^ c_out_msb;
  endfunction

  assign accept   = in_valid && in_ready;
  assign sample   = (state_q == WAIT) && lat_zero;
  assign last_bit = (bit_idx_q == LAST_IDX);

  bsa_lat_timer #(
    .FA_LAT (FA_LAT)
  ) u_lat_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state_q == ISSUE),
    .en    (state_q == WAIT),
    .zero  (lat_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    fa_issue  = 1'b0;
    fa_a      = 1'b0;
    fa_b      = 1'b0;
    fa_c      = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ISSUE;
      end
      ISSUE: begin
        fa_issue = 1'b1;
        fa_a     = a_q[bit_idx_q];
        fa_b     = b_q[bit_idx_q];
        fa_c     = carry_q;
        state_d  = WAIT;
      end
      WAIT: begin
        if (lat_zero) state_d = last_bit ? DONE : ISSUE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture on accept; one sum bit and the next carry per sample strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      bit_idx_q <= '0;
      carry_q   <= 1'b0;
      msb_cin_q <= 1'b0;
    end else if (accept) begin
      a_q       <= in_a;
      b_q       <= in_b;
      sum_q     <= '0;
      bit_idx_q <= '0;
      carry_q   <= in_cin;
      msb_cin_q <= 1'b0;
    end else if (sample) begin
      sum_q[bit_idx_q] <= fa_s;
      carry_q          <= fa_cout;
      if (last_bit) begin
        msb_cin_q <= carry_q;
      end else begin
        bit_idx_q <= bit_idx_q + 1'b1;
      end
    end
  end

  // Nothing above changes in DONE, so the result is stable under backpressure.
  assign out_sum  = sum_q;
  assign out_cout = carry_q;
  assign out_ovf  = ovf_of(msb_cin_q, carry_q);

endmodule

// File: tb/tb_bit_serial_add_sequencer.sv
// Bench for bit_serial_add_sequencer: main instance (WIDTH=8, FA_LAT=8) with
// directed vectors, plus two parameter-sweep instances with random operands.
// Each instance has its own delay-line full-adder model and scoreboard queue.
module tb_bit_serial_add_sequencer;

  localparam int W   = 8;
  localparam int L   = 8;
  localparam int LAT = W * (L + 1) + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         srst_n = 1'b0;
  logic         in_valid, in_ready, in_cin;
  logic [W-1:0] in_a, in_b;
  logic         fa_a, fa_b, fa_c, fa_issue, fa_s, fa_cout;
  logic         out_valid, out_ready, out_cout, out_ovf;
  logic [W-1:0] out_sum;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  int ndone  = 0;
  int nexp   = 0;
  int iss_cnt = 0;
  int idle_viol = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #23 srst_n = 1'b1;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    ntests++;
    nfail++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  bit_serial_add_sequencer #(.WIDTH(W), .FA_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c), .fa_issue(fa_issue),
    .fa_s(fa_s), .fa_cout(fa_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  // Full-adder model: L-deep delay line, not reset.
  logic [L-1:0] ds = '0, dc = '0;
  always @(posedge clk) begin
    ds <= (ds << 1) | L'(fa_a ^ fa_b ^ fa_c);
    dc <= (dc << 1) | L'((fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c));
  end
  assign fa_s    = ds[L-1];
  assign fa_cout = dc[L-1];

  // Monitor for the main instance.
  initial begin : mon
    int last_iss;
    int rise_cyc;
    logic vld_prev;
    exp_t e;
    last_iss = 0; rise_cyc = 0; vld_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!fa_issue && (fa_a || fa_b || fa_c)) idle_viol++;
      if (!rst_n) begin
        iss_cnt  = 0;
        vld_prev = 1'b0;
      end else begin
        if (fa_issue) begin
          if (iss_cnt > 0) chk("issue_spacing", cyc - last_iss, L + 1);
          last_iss = cyc;
          iss_cnt++;
        end
        if (out_valid && !vld_prev) rise_cyc = cyc;
        vld_prev = out_valid;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            flag("unexpected_result");
          end else begin
            e = sb.pop_front();
            chk("sum", out_sum, e.sum);
            chk("cout", out_cout, e.cout);
            chk("ovf", out_ovf, e.ovf);
            chk("latency", rise_cyc - e.acc, LAT);
            chk("issue_count", iss_cnt, W);
          end
          iss_cnt = 0;
          ndone++;
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input logic [W-1:0] es, input logic ec, input logic eo);
    exp_t e;
    int n;
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n == 200) begin
      flag("accept_timeout");
    end else begin
      e.sum = es; e.cout = ec; e.ovf = eo; e.acc = cyc;
      sb.push_back(e);
      nexp++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    for (n = 0; n < 400; n++) begin
      if (ndone >= nexp) break;
      @(posedge clk);
    end
    if (ndone < nexp) flag("result_timeout");
    #1;
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                     input logic [W-1:0] es, input logic ec, input logic eo);
    send(a, b, c, es, ec, eo);
    wait_done();
  endtask

  // Parameter sweep instances.
  for (genvar g = 0; g < 2; g++) begin : g_sw
    localparam int SW   = (g == 0) ? 2 : 16;
    localparam int SL   = (g == 0) ? 1 : 5;
    localparam int SLAT = SW * (SL + 1) + 1;

    logic          iv, ir, ic, fa, fb, fc, fi, fs, fco, ov, orr, oc, oo;
    logic [SW-1:0] ia, ib, os;
    logic [SL-1:0] ss = '0, sc = '0;
    logic          fin = 1'b0;
    int            sdone = 0;

    typedef struct {
      logic [SW-1:0] sum;
      logic          cout;
      logic          ovf;
      int            acc;
    } sexp_t;
    sexp_t q[$];

    bit_serial_add_sequencer #(.WIDTH(SW), .FA_LAT(SL)) u_sw (
      .clk(clk), .rst_n(srst_n),
      .in_valid(iv), .in_ready(ir),
      .in_a(ia), .in_b(ib), .in_cin(ic),
      .fa_a(fa), .fa_b(fb), .fa_c(fc), .fa_issue(fi),
      .fa_s(fs), .fa_cout(fco),
      .out_valid(ov), .out_ready(orr),
      .out_sum(os), .out_cout(oc), .out_ovf(oo)
    );

    always @(posedge clk) begin
      ss <= (ss << 1) | SL'(fa ^ fb ^ fc);
      sc <= (sc << 1) | SL'((fa & fb) | (fa & fc) | (fb & fc));
    end
    assign fs  = ss[SL-1];
    assign fco = sc[SL-1];

    initial begin : sstim
      logic [SW-1:0] a, b;
      logic          c;
      logic [SW:0]   full;
      sexp_t         e;
      int            n;
      iv = 1'b0; orr = 1'b1; ia = '0; ib = '0; ic = 1'b0;
      @(posedge srst_n);
      @(posedge clk);
      #1;
      for (int t = 0; t < 6; t++) begin
        a = SW'($urandom);
        b = SW'($urandom);
        c = 1'($urandom_range(0, 1));
        if (t == 0) begin a = '1; b = '0; c = 1'b1; end
        full   = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, c};
        e.sum  = full[SW-1:0];
        e.cout = full[SW];
        e.ovf  = (a[SW-1] == b[SW-1]) && (e.sum[SW-1] != a[SW-1]);
        iv = 1'b1; ia = a; ib = b; ic = c;
        for (n = 0; n < 50; n++) begin
          @(negedge clk);
          if (ir) break;
        end
        if (n == 50) begin
          flag("sw_accept_timeout");
        end else begin
          e.acc = cyc;
          q.push_back(e);
        end
        @(posedge clk);
        #1 iv = 1'b0;
        for (n = 0; n < 2000; n++) begin
          if (sdone > t) break;
          @(posedge clk);
        end
        if (sdone <= t) flag("sw_result_timeout");
        #1;
      end
      fin = 1'b1;
    end

    initial begin : smon
      int    rise;
      logic  prev;
      sexp_t e;
      rise = 0; prev = 1'b0;
      forever begin
        @(negedge clk);
        if (ov && !prev) rise = cyc;
        prev = ov;
        if (ov && orr) begin
          if (q.size() == 0) begin
            flag("sw_unexpected_result");
          end else begin
            e = q.pop_front();
            chk("sw_sum", os, e.sum);
            chk("sw_cout", oc, e.cout);
            chk("sw_ovf", oo, e.ovf);
            chk("sw_latency", rise - e.acc, SLAT);
          end
          sdone++;
        end
      end
    end
  end

  // Main stimulus.
  initial begin : stim
    int n;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fa_issue", fa_issue, 0);
    chk("rst_fa_abc", {fa_a, fa_b, fa_c}, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_cout_ovf", {out_cout, out_ovf}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    run(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    run(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    run(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    // Backpressure in DONE for 10 cycles with a competing operand offer.
    out_ready = 1'b0;
    send(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 1'b0);
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    if (!out_valid) flag("bp_valid_timeout");
    in_valid = 1'b1; in_a = 8'hF0; in_b = 8'h0F; in_cin = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold", {out_sum, out_cout, out_ovf}, {8'h7E, 1'b0, 1'b0});
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_out_valid", out_valid, 0);
    chk("post_hs_done", ndone, nexp);
    run(8'h01, 8'h02, 1'b1, 8'h04, 1'b0, 1'b0);

    // Reset during WAIT of bit 3; that transaction must vanish.
    send(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    for (n = 0; n < 100; n++) begin
      if (iss_cnt >= 4) break;
      @(posedge clk);
    end
    if (iss_cnt < 4) flag("bit3_issue_timeout");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_fa", {fa_issue, fa_a, fa_b, fa_c}, 0);
    chk("mid_rst_out", {out_sum, out_cout, out_ovf}, 0);
    if (sb.size() > 0) begin
      void'(sb.pop_front());
      nexp--;
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0);

    for (n = 0; n < 5000; n++) begin
      if (g_sw[0].fin && g_sw[1].fin) break;
      @(posedge clk);
    end
    if (!(g_sw[0].fin && g_sw[1].fin)) flag("sweep_timeout");
    chk("fa_idle_zero", idle_viol, 0);
    chk("sb_empty", sb.size(), 0);
    chk("results_done", ndone, nexp);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
